vx_dispatch_arbiter: RTL and testbench
======================================

# vx_dispatch_arbiter

Round-robin arbiter that shares one functional-unit dispatch port among `ISSUE_WIDTH` issue slices. It sits between the per-slice dispatch outputs of the issue stage and a single shared execution unit, such as the SFU or a narrow LSU. Grants can be locked across multi-packet instructions. Per-slice branch-mispredict flushes drop both pending requests and the buffered packet, and a stall counter feeds the perf interface.

## Interface
- `NUM_REQS`, default `ISSUE_WIDTH`: number of requesting issue slices (≥1).
- `DATAW`, default 64: dispatch payload width in bits.
- `SELW`, default `CLOG2(NUM_REQS)` (min 1): width of the selected-slice index.
- `PERF_W`, default `PERF_CTR_BITS`: stall counter width.
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high reset.
- `flush`, in, `NUM_REQS`: per-slice branch-mispredict flush.
- `in_valid`, in, `NUM_REQS`: per-slice request valid.
- `in_eop`, in, `NUM_REQS`: last packet of the instruction; 0 means more packets follow.
- `in_data`, in, `NUM_REQS*DATAW`: per-slice payload; slice i occupies bits [i*DATAW +: DATAW].
- `in_ready`, out, `NUM_REQS`: per-slice accept.
- `out_valid`, out, 1: packet available to the execution unit.
- `out_data`, out, `DATAW`: buffered payload.
- `out_sel`, out, `SELW`: slice index of the buffered packet.
- `out_eop`, out, 1: buffered packet's eop.
- `out_ready`, in, 1: execution unit accepts.
- `perf_stalls`, out, `PERF_W`: count of cycles with ≥1 eligible request not accepted.

## Operation
- **Output register:** one entry holds `{data, sel, eop, valid_r}`.
  - `out_valid = valid_r & ~flush[sel_r]`, so a flush takes effect combinationally.
  - `can_load = ~valid_r | out_ready | flush[sel_r]`.
- **Eligible requests:** `req = in_valid & ~flush`. A flushed slice is never granted in that cycle.
- **States:**
  - **UNLOCKED:** the winner is the first set bit of `req` searching upward from `rr_ptr`, wrapping at `NUM_REQS-1`→0.
  - **LOCKED(lock_idx):** only `req[lock_idx]` is eligible; all other slices see `in_ready=0`.
- **Grant and load:**
  - `in_ready[i] = grant[i] & can_load`.
  - The register loads on fire, meaning any `in_valid[i] & in_ready[i]`.
- **Transitions on fire of slice w:**
  - `rr_ptr <= (w+1) mod NUM_REQS`.
  - If `in_eop[w]=0`: go to LOCKED with `lock_idx=w`.
  - If `in_eop[w]=1`: go to UNLOCKED.
- **Flush of `lock_idx` while LOCKED:** return to UNLOCKED. `rr_ptr` is unchanged.
- **Register update when `can_load` is true and there is no fire:** `valid_r <= 0`.
- **Stall counter:**
  - Increments when `|req & ~|(in_valid & in_ready)`.
  - Saturates at all-ones.
- **Reset:**
  - `valid_r=0`, so `out_valid=0`.
  - `out_sel=0`, `out_data=0`, `out_eop=0`.
  - `rr_ptr=0`, state UNLOCKED, `perf_stalls=0`.
  - All `in_ready` are 0 during reset.
  - Reset mid-lock abandons the lock.

## Timing
- **Latency:** 1 cycle from input fire to `out_valid`.
- **Throughput:** 1 packet per cycle when `out_ready` is held high.
- **Handshake:**
  - `out_valid` and `out_data` stay stable until `out_ready` or a flush of `out_sel`.
  - Requesters must hold `in_valid` and `in_data` until `in_ready`.
- **`in_ready` dependencies:**
  - `in_ready` depends combinationally on `out_ready` and `flush`.
  - `in_ready` does not depend on `in_valid` of other slices while LOCKED.
- **Flush concurrent with output fire:** the entry is dropped and the unit sees `out_valid=0`.
- **Flush of slice i with new data from slice j≠i in the same cycle:** j loads normally.
- **`NUM_REQS=1`:**
  - `rr_ptr` is constant 0 and `out_sel` is 0.
  - Locking still applies.

## Structure
- Combinational sub-module `vx_rr_priority`: inputs `req` and `ptr`; outputs a one-hot grant and an index. No state.
- Lock/pointer FSM, output register and counter live in `vx_dispatch_arbiter`.
- `PERF_CTR_BITS` and `ISSUE_WIDTH` come from the shared `VX_gpu_pkg`. The state enum `{UNLOCKED, LOCKED}` belongs in the same package.

## Test plan
- **Round-robin fairness:** `NUM_REQS=4`, all `in_valid=1`, `eop=1`, `out_ready=1` → `out_sel` sequence 0,1,2,3,0 on consecutive cycles.
- **Lock:** slice 2 sends three packets with eop 0,0,1 while slices 0 and 3 request → `out_sel`=2,2,2, then 3, then 0. `in_ready[0]` and `in_ready[3]` stay 0 during the lock.
- **Backpressure:** `out_ready=0` for 5 cycles with slice 1 valid → `out_valid` held with stable data, `in_ready=0`, `perf_stalls` += 5.
- **Flush of buffered entry:** the entry is from slice 1 and `flush[1]` pulses → `out_valid=0` in the same cycle. The next cycle loads slice 3's pending request.
- **Flush mid-lock:** slice 0 is locked after eop=0 and `flush[0]` arrives → state UNLOCKED. Slice 1 is granted in the next eligible cycle.
- **Reset mid-operation:** reset while locked with `valid_r=1` → next cycle `out_valid=0`, `perf_stalls=0`, first grant goes to slice 0.

Source files
------------

// File: rtl/vx_dispatch_arbiter_pkg.sv
// Shared GPU-wide constants and the dispatch arbiter lock state.
package VX_gpu_pkg;

  localparam int ISSUE_WIDTH   = 4;
  localparam int PERF_CTR_BITS = 44;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } arb_state_e;

endpackage

// File: rtl/vx_dispatch_arbiter_rr_priority.sv
// Round-robin priority picker: first set bit of req at or above ptr, wrapping.
module vx_rr_priority #(
  parameter int NUM_REQS = 4,
  parameter int SELW     = 2
) (
  input  logic [NUM_REQS-1:0] req,
  input  logic [SELW-1:0]     ptr,
  output logic [NUM_REQS-1:0] grant,
  output logic [SELW-1:0]     idx
);

  function automatic int wrap_idx(input int p, input int o);
    return (p + o) % NUM_REQS;
  endfunction

  // Scan farthest offset first so the closest requester overwrites.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int off = NUM_REQS - 1; off >= 0; off--) begin
      if (req[wrap_idx(int'(ptr), off)]) begin
        grant = '0;
        grant[wrap_idx(int'(ptr), off)] = 1'b1;
        idx = SELW'(wrap_idx(int'(ptr), off));
      end
    end
  end

endmodule

// File: rtl/vx_dispatch_arbiter.sv
// Shares one execution-unit dispatch port among issue slices with round-robin
// arbitration, multi-packet grant locking, per-slice flush and a stall counter.
module vx_dispatch_arbiter
  import VX_gpu_pkg::*;
#(
  parameter int NUM_REQS = ISSUE_WIDTH,
  parameter int DATAW    = 64,
  parameter int SELW     = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
  parameter int PERF_W   = PERF_CTR_BITS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       flush,
  input  logic [NUM_REQS-1:0]       in_valid,
  input  logic [NUM_REQS-1:0]       in_eop,
  input  logic [NUM_REQS*DATAW-1:0] in_data,
  output logic [NUM_REQS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  output logic                      out_eop,
  input  logic                      out_ready,
  output logic [PERF_W-1:0]         perf_stalls
);

  arb_state_e          state_q, state_d;
  logic [SELW-1:0]     lock_idx_q, lock_idx_d;
  logic [SELW-1:0]     rr_ptr_q, rr_ptr_d;
  logic                valid_q, valid_d;
  logic [DATAW-1:0]    data_q, data_d;
  logic [SELW-1:0]     sel_q, sel_d;
  logic                eop_q, eop_d;
  logic [PERF_W-1:0]   perf_q, perf_d;

  logic [NUM_REQS-1:0] req, elig, lock_mask, grant;
  logic [SELW-1:0]     grant_idx;
  logic                sel_flush, lock_flush, can_load, fire, win_eop;
  logic [DATAW-1:0]    win_data;

  always_comb begin
    sel_flush = 1'b0;
    lock_mask = '1;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (sel_q == SELW'(i)) sel_flush = flush[i];
      if (state_q == LOCKED && lock_idx_q != SELW'(i)) lock_mask[i] = 1'b0;
    end
  end

  assign req        = in_valid & ~flush;
  assign elig       = req & lock_mask;
  assign lock_flush = (state_q == LOCKED) && |(flush & lock_mask);
  assign can_load   = ~valid_q | out_ready | sel_flush;

  vx_rr_priority #(
    .NUM_REQS (NUM_REQS),
    .SELW     (SELW)
  ) u_rr_priority (
    .req   (elig),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx)
  );

  assign in_ready = reset ? '0 : (grant & {NUM_REQS{can_load}});
  assign fire     = |(in_valid & in_ready);

  always_comb begin
    win_data = '0;
    win_eop  = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (grant[i]) begin
        win_data = in_data[i*DATAW +: DATAW];
        win_eop  = in_eop[i];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    rr_ptr_d   = rr_ptr_q;
    valid_d    = valid_q;
    data_d     = data_q;
    sel_d      = sel_q;
    eop_d      = eop_q;
    perf_d     = perf_q;

    if (fire) begin
      rr_ptr_d   = (int'(grant_idx) == NUM_REQS - 1) ? '0 : grant_idx + SELW'(1);
      state_d    = win_eop ? UNLOCKED : LOCKED;
      lock_idx_d = grant_idx;
    end else if (lock_flush) begin
      state_d = UNLOCKED;
    end

    if (can_load) begin
      valid_d = fire;
      if (fire) begin
        data_d = win_data;
        sel_d  = grant_idx;
        eop_d  = win_eop;
      end
    end

    if (|req && !fire && perf_q != '1) perf_d = perf_q + PERF_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= UNLOCKED;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sel_q      <= '0;
      eop_q      <= 1'b0;
      perf_q     <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sel_q      <= sel_d;
      eop_q      <= eop_d;
      perf_q     <= perf_d;
    end
  end

  // A flush of the buffered slice hides the entry in the same cycle.
  assign out_valid   = valid_q & ~sel_flush;
  assign out_data    = data_q;
  assign out_sel     = sel_q;
  assign out_eop     = eop_q;
  assign perf_stalls = perf_q;

endmodule

// File: tb/tb_vx_dispatch_arbiter.sv
// Directed bench for vx_dispatch_arbiter with four slices.
module tb_vx_dispatch_arbiter;

  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = 2;
  localparam int PW = 44;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    flush, in_valid, in_eop, in_ready;
  logic [N*DW-1:0] in_data;
  logic            out_valid, out_eop, out_ready;
  logic [DW-1:0]   out_data;
  logic [SW-1:0]   out_sel;
  logic [PW-1:0]   perf_stalls;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  vx_dispatch_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_eop      (in_eop),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_sel     (out_sel),
    .out_eop     (out_eop),
    .out_ready   (out_ready),
    .perf_stalls (perf_stalls)
  );

  function automatic logic [DW-1:0] mkdata(input int i, input int k);
    return 64'hA5A5_0000_0000_0000 | (64'(i) << 16) | 64'(k);
  endfunction

  task automatic set_data(input int i, input logic [DW-1:0] d);
    in_data[i*DW +: DW] = d;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic before_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    before_edge();
    reset = 1'b1; flush = '0; in_valid = '1; in_eop = '1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) set_data(i, mkdata(i, 0));
    after_edge(); after_edge();
    #1;
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (out_sel !== 2'd0 || out_eop !== 1'b0 || out_data !== 64'd0) begin
      fails++; $display("FAIL reset_out_regs got sel=%0d eop=%b data=%h exp 0/0/0", out_sel, out_eop, out_data); end
    tests++; if (perf_stalls !== 44'd0) begin fails++; $display("FAIL reset_perf got %0d exp 0", perf_stalls); end
    before_edge();
    reset = 1'b0; in_valid = '0;
  endtask

  // All slices valid with eop=1: grants rotate 0,1,2,3,0; rr_ptr ends at 1.
  task automatic test_round_robin();
    before_edge();
    in_valid = 4'b1111; in_eop = 4'b1111; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      after_edge();
      tests++; if (out_valid !== 1'b1 || out_sel !== SW'(k % N) || out_data !== mkdata(k % N, 0)) begin
        fails++; $display("FAIL rr_seq k=%0d got v=%b sel=%0d data=%h exp v=1 sel=%0d data=%h",
                          k, out_valid, out_sel, out_data, k % N, mkdata(k % N, 0)); end
    end
    before_edge();
    in_valid = '0;
    after_edge();
    tests++; if (out_valid !== 1'b0 || perf_stalls !== 44'd0) begin
      fails++; $display("FAIL rr_drain got v=%b perf=%0d exp v=0 perf=0", out_valid, perf_stalls); end
  endtask

  // rr_ptr=1; slices 0,2,3 request; slice 2 wins and locks for three packets.
  task automatic test_lock();
    logic [N-1:0] exp_rdy [6];
    logic [SW-1:0] exp_sel [6];
    exp_rdy = '{4'b0100, 4'b0100, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
    exp_sel = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd0, 2'd0};
    before_edge();
    out_ready = 1'b1; in_eop = 4'b1011; in_valid = 4'b1101;
    set_data(2, mkdata(2, 0));
    for (int k = 0; k < 5; k++) begin
      #1;
      tests++; if (in_ready !== exp_rdy[k]) begin
        fails++; $display("FAIL lock_ready k=%0d got %b exp %b", k, in_ready, exp_rdy[k]); end
      after_edge();
      tests++; if (out_valid !== 1'b1 || out_sel !== exp_sel[k]) begin
        fails++; $display("FAIL lock_sel k=%0d got v=%b sel=%0d exp v=1 sel=%0d", k, out_valid, out_sel, exp_sel[k]); end
      if (k < 3) begin
        tests++; if (out_data !== mkdata(2, k) || out_eop !== (k == 2)) begin
          fails++; $display("FAIL lock_pkt k=%0d got data=%h eop=%b exp data=%h eop=%b",
                            k, out_data, out_eop, mkdata(2, k), k == 2); end
      end
      before_edge();
      if (k == 0) set_data(2, mkdata(2, 1));
      if (k == 1) begin set_data(2, mkdata(2, 2)); in_eop[2] = 1'b1; end
      if (k == 2) in_valid[2] = 1'b0;
      if (k == 3) in_valid[3] = 1'b0;
      if (k == 4) in_valid[0] = 1'b0;
    end
    after_edge();
    tests++; if (out_valid !== 1'b0 || perf_stalls !== 44'd0) begin
      fails++; $display("FAIL lock_drain got v=%b perf=%0d exp v=0 perf=0", out_valid, perf_stalls); end
  endtask

  // rr_ptr=1; slice 1 loads, then out_ready=0 for five cycles.
  task automatic test_backpressure();
    before_edge();
    in_valid = 4'b0010; in_eop = 4'b1111; out_ready = 1'b0;
    set_data(1, mkdata(1, 5));
    after_edge();
    before_edge();
    set_data(1, mkdata(1, 6));
    for (int k = 0; k < 5; k++) begin
      after_edge();
      tests++; if (out_valid !== 1'b1 || out_data !== mkdata(1, 5) || in_ready !== 4'b0000) begin
        fails++; $display("FAIL bp_hold k=%0d got v=%b data=%h rdy=%b exp v=1 data=%h rdy=0000",
                          k, out_valid, out_data, in_ready, mkdata(1, 5)); end
    end
    tests++; if (perf_stalls !== 44'd5) begin fails++; $display("FAIL bp_perf got %0d exp 5", perf_stalls); end
    before_edge();
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL bp_release_ready got %b exp 0010", in_ready); end
    after_edge();
    tests++; if (out_data !== mkdata(1, 6) || perf_stalls !== 44'd5) begin
      fails++; $display("FAIL bp_release got data=%h perf=%0d exp data=%h perf=5", out_data, perf_stalls, mkdata(1, 6)); end
    before_edge();
    in_valid = '0;
    after_edge();
  endtask

  // rr_ptr=2; slice 1 buffered under backpressure, slice 3 pending, flush[1].
  task automatic test_flush_buffered();
    before_edge();
    in_valid = 4'b0010; out_ready = 1'b0;
    set_data(1, mkdata(1, 7));
    after_edge();
    before_edge();
    in_valid = 4'b1000;
    set_data(3, mkdata(3, 1));
    after_edge();
    before_edge();
    flush = 4'b0010;
    #1;
    tests++; if (out_valid !== 1'b0 || in_ready !== 4'b1000) begin
      fails++; $display("FAIL flbuf_same got v=%b rdy=%b exp v=0 rdy=1000", out_valid, in_ready); end
    after_edge();
    before_edge();
    flush = '0; in_valid = '0;
    #1;
    tests++; if (out_valid !== 1'b1 || out_sel !== 2'd3 || out_data !== mkdata(3, 1) || perf_stalls !== 44'd6) begin
      fails++; $display("FAIL flbuf_next got v=%b sel=%0d data=%h perf=%0d exp v=1 sel=3 data=%h perf=6",
                        out_valid, out_sel, out_data, perf_stalls, mkdata(3, 1)); end
    out_ready = 1'b1;
    after_edge();
  endtask

  // rr_ptr=0; slice 0 locks with eop=0, then flush[0] while slice 1 waits.
  task automatic test_flush_lock();
    before_edge();
    in_valid = 4'b0011; in_eop = 4'b1110; out_ready = 1'b1;
    set_data(0, mkdata(0, 3)); set_data(1, mkdata(1, 8));
    #1;
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL fllock_first got %b exp 0001", in_ready); end
    after_edge();
    before_edge();
    flush = 4'b0001;
    #1;
    tests++; if (in_ready !== 4'b0000 || out_valid !== 1'b0) begin
      fails++; $display("FAIL fllock_during got rdy=%b v=%b exp rdy=0000 v=0", in_ready, out_valid); end
    after_edge();
    before_edge();
    flush = '0; in_valid = 4'b0010;
    #1;
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL fllock_unlock got %b exp 0010", in_ready); end
    after_edge();
    tests++; if (out_valid !== 1'b1 || out_sel !== 2'd1 || perf_stalls !== 44'd7) begin
      fails++; $display("FAIL fllock_grant got v=%b sel=%0d perf=%0d exp v=1 sel=1 perf=7", out_valid, out_sel, perf_stalls); end
    before_edge();
    in_valid = '0; in_eop = '1;
    after_edge();
  endtask

  // rr_ptr=2; slice 2 locks with a held entry, then reset mid-lock.
  task automatic test_reset_mid();
    before_edge();
    in_valid = 4'b0100; in_eop = 4'b1011; out_ready = 1'b0;
    after_edge();
    before_edge();
    in_valid = 4'b0101;
    after_edge();
    tests++; if (out_valid !== 1'b1 || perf_stalls !== 44'd8) begin
      fails++; $display("FAIL rstmid_pre got v=%b perf=%0d exp v=1 perf=8", out_valid, perf_stalls); end
    before_edge();
    reset = 1'b1; in_eop = 4'b1111;
    #1;
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL rstmid_ready got %b exp 0000", in_ready); end
    after_edge();
    before_edge();
    reset = 1'b0; out_ready = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0 || perf_stalls !== 44'd0 || in_ready !== 4'b0001) begin
      fails++; $display("FAIL rstmid_after got v=%b perf=%0d rdy=%b exp v=0 perf=0 rdy=0001",
                        out_valid, perf_stalls, in_ready); end
    after_edge();
    tests++; if (out_valid !== 1'b1 || out_sel !== 2'd0) begin
      fails++; $display("FAIL rstmid_grant got v=%b sel=%0d exp v=1 sel=0", out_valid, out_sel); end
    before_edge();
    in_valid = '0;
  endtask

  initial begin
    reset = 1'b1; flush = '0; in_valid = '0; in_eop = '1; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_round_robin();
    test_lock();
    test_backpressure();
    test_flush_buffered();
    test_flush_lock();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
